// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel valid/ready arbitrating mux (fixed/round-robin/forced) into a one-entry output register; ports clk, rst_n, mode, sel, in_data/in_valid/in_ready, out_data/out_chan/out_valid/out_ready
module rr_mux_arbiter #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SEL_W-1:0] ptr, fp_i, rr_i, gnt_i;
  logic fp_v, rr_v, gnt_v, can_accept, fire;
  always_comb begin
    fp_v = 1'b0;
    fp_i = '0;
    rr_v = 1'b0;
    rr_i = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (in_valid[i]) begin
        fp_v = 1'b1;
        fp_i = SEL_W'(i);
      end
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (in_valid[(int'(ptr) + k) % CHANNELS]) begin
        rr_v = 1'b1;
        rr_i = SEL_W'((int'(ptr) + k) % CHANNELS);
      end
    gnt_v = mode == 2'b01 ? rr_v : mode == 2'b10 ? (int'(sel) < CHANNELS && in_valid[sel]) : fp_v;
    gnt_i = mode == 2'b01 ? rr_i : mode == 2'b10 ? sel : fp_i;
  end
  assign can_accept = !out_valid | out_ready;
  assign in_ready = (gnt_v & can_accept & rst_n) ? CHANNELS'(1) << gnt_i : '0;
  assign fire = |in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      ptr <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data <= in_data[int'(gnt_i)*WIDTH +: WIDTH];
      out_chan <= gnt_i;
      if (mode == 2'b01) ptr <= gnt_i == SEL_W'(CHANNELS - 1) ? '0 : gnt_i + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of a 4-channel and a 3-channel rr_mux_arbiter
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] sel = 2'd0;
  logic [31:0] in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0] in_valid = 4'b0000;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [23:0] in_data3 = {8'hC2, 8'hC1, 8'hC0};
  logic [2:0] in_valid3 = 3'b000;
  logic [2:0] in_ready3;
  logic [7:0] out_data3;
  logic [1:0] out_chan3;
  logic out_valid3;
  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 4'b1111;
    tick();
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan got %0d exp 0", out_chan); end
    in_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed;
    mode = 2'b00;
    in_data = {8'h33, 8'hA2, 8'h11, 8'hA0};
    in_valid = 4'b1010;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready got %b exp 0010", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 2'd1) begin errors++; $display("FAIL fixed_first got v=%b d=%h c=%0d exp v=1 d=11 c=1", out_valid, out_data, out_chan); end
    in_valid = 4'b1000;
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL fixed_ready3 got %b exp 1000", in_ready); end
    tick();
    checks++; if (out_data !== 8'h33 || out_chan !== 2'd3) begin errors++; $display("FAIL fixed_second got d=%h c=%0d exp d=33 c=3", out_data, out_chan); end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h33 || out_chan !== 2'd3) begin errors++; $display("FAIL fixed_drain got v=%b d=%h c=%0d exp v=0 d=33 c=3", out_valid, out_data, out_chan); end
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask

  task automatic test_round_robin;
    mode = 2'b01;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== 8'hA0 + 8'(i % 4)) begin errors++; $display("FAIL rr_seq[%0d] got v=%b c=%0d d=%h exp v=1 c=%0d", i, out_valid, out_chan, out_data, i % 4); end
    end
  endtask

  task automatic test_backpressure;
    tick();
    checks++; if (out_chan !== 2'd1 || out_data !== 8'hA1) begin errors++; $display("FAIL bp_capture got c=%0d d=%h exp c=1 d=a1", out_chan, out_data); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 8'hA1) begin errors++; $display("FAIL bp_hold[%0d] got v=%b c=%0d d=%h exp v=1 c=1 d=a1", i, out_valid, out_chan, out_data); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", in_ready); end
    tick();
    checks++; if (out_chan !== 2'd2 || out_data !== 8'hA2) begin errors++; $display("FAIL bp_release got c=%0d d=%h exp c=2 d=a2", out_chan, out_data); end
    tick();
    checks++; if (out_chan !== 2'd3) begin errors++; $display("FAIL bp_next got c=%0d exp 3", out_chan); end
  endtask

  task automatic test_forced;
    mode = 2'b10;
    sel = 2'd2;
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL forced_ready[%0d] got %b exp 0100", i, in_ready); end
      tick();
      checks++; if (out_chan !== 2'd2 || out_data !== 8'hA2) begin errors++; $display("FAIL forced_out[%0d] got c=%0d d=%h exp c=2 d=a2", i, out_chan, out_data); end
    end
    in_valid = 4'b1011;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL forced_idle_ready got %b exp 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'hA2) begin errors++; $display("FAIL forced_drain got v=%b d=%h exp v=0 d=a2", out_valid, out_data); end
  endtask

  task automatic test_reset_mid;
    mode = 2'b01;
    in_valid = 4'b1111;
    tick();
    checks++; if (out_chan !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_capture got c=%0d v=%b exp c=0 v=1", out_chan, out_valid); end
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready_in_reset got %b exp 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin errors++; $display("FAIL rm_cleared got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, out_chan); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_ready got %b exp 0001", in_ready); end
    tick();
    checks++; if (out_chan !== 2'd0 || out_data !== 8'hA0) begin errors++; $display("FAIL rm_first got c=%0d d=%h exp c=0 d=a0", out_chan, out_data); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_mode3;
    mode = 2'b11;
    in_valid = 4'b0110;
    in_valid3 = 3'b110;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL m3_ready got %b exp 0010", in_ready); end
    checks++; if (in_ready3 !== 3'b010) begin errors++; $display("FAIL m3_ready3 got %b exp 010", in_ready3); end
    tick();
    checks++; if (out_chan !== 2'd1 || out_data !== 8'hA1) begin errors++; $display("FAIL m3_out got c=%0d d=%h exp c=1 d=a1", out_chan, out_data); end
    checks++; if (out_chan3 !== 2'd1 || out_data3 !== 8'hC1) begin errors++; $display("FAIL m3_out3 got c=%0d d=%h exp c=1 d=c1", out_chan3, out_data3); end
    in_valid = 4'b0000;
    in_valid3 = 3'b000;
    tick();
  endtask

  task automatic test_three_channels;
    mode = 2'b10;
    sel = 2'd3;
    in_valid3 = 3'b111;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL ch3_sel_oob got %b exp 000", in_ready3); end
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid3 !== 1'b1 || out_chan3 !== 2'(i % 3) || out_data3 !== 8'hC0 + 8'(i % 3)) begin errors++; $display("FAIL ch3_rr[%0d] got v=%b c=%0d d=%h exp v=1 c=%0d", i, out_valid3, out_chan3, out_data3, i % 3); end
    end
    in_valid3 = 3'b000;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_forced();
    test_reset_mid();
    test_mode3();
    test_three_channels();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Parametrised N-channel arbitrating multiplexer with a valid/ready handshake on every input and on the output. It replaces the fixed 4:1 decoder-select mux wherever several producers share one consumer. Each cycle it picks one requesting channel using fixed-priority, round-robin or forced-select mode, and captures that channel's word in a one-entry output register. The output register holds its word until the consumer accepts it.

Parameters:
WIDTH, 8, data width of each channel and of the output
CHANNELS, 4, number of input channels; must be >= 2
SEL_W, $clog2(CHANNELS), derived localparam giving the width of the channel index; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
mode  input  2  arbitration mode: 00 fixed priority, 01 round-robin, 10 forced select, 11 treated as 00
sel  input  SEL_W  channel index used in forced mode; ignored in other modes
in_data  input  CHANNELS*WIDTH  packed channel words; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel request
in_ready  output  CHANNELS  per-channel accept; at most one bit is high in any cycle
out_data  output  WIDTH  registered selected word
out_chan  output  SEL_W  registered index of the source channel of out_data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (rst_n low at a clock edge):
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer=0.
  - in_ready=all zeros in every cycle where rst_n is low, even though in_ready is combinational.
  - A reset applied mid-transfer discards the buffered word. No handshake completes on that edge.
- can_accept = !out_valid | out_ready. The block sustains full throughput of one word per cycle while out_ready stays high.
- Grant is combinational from in_valid, mode, sel and the pointer. in_ready[g] = grant[g] & can_accept & rst_n.
- A transfer from channel g occurs when in_valid[g] & in_ready[g]. On that edge: out_data <= channel g word, out_chan <= g, out_valid <= 1.
- If out_valid & out_ready and no input transfer occurs on the same edge: out_valid <= 0. out_data and out_chan keep their last values.
- While out_valid=1 and out_ready=0, out_data and out_chan are held stable.
- Fixed priority: grant goes to the lowest index i with in_valid[i]=1.
- Round-robin:
  - Search starts at the pointer and proceeds upward, wrapping from CHANNELS-1 to 0.
  - After a transfer from g, pointer <= (g+1) mod CHANNELS. The wrap applies for non-power-of-two CHANNELS too.
  - The pointer advances only on an actual transfer, never on an offer that is stalled by out_ready=0.
- Forced select: grant goes to channel sel only if in_valid[sel]=1; otherwise no grant. If sel >= CHANNELS, there is no grant.
- The pointer is retained across mode changes and updates only in round-robin mode. A mode or sel change takes effect in the same cycle's combinational grant.
- No request, or a stall: no in_ready is high, the pointer is unchanged and the output register is unchanged (except for the drain described above).
- Latency: one cycle from input handshake to out_valid.
- Multiple requests in one cycle: exactly one is granted. The losing channels keep in_valid high and their data stable; no data is dropped.

Test Plan:
- Reset, then fixed mode, in_valid=4'b1010 with d1=8'h11 and d3=8'h33, out_ready=1 → in_ready=4'b0010; next cycle out_data=8'h11, out_chan=1; then channel 3 is granted once in_valid[1] drops.
- Round-robin, all four channels valid continuously (d0..d3=8'hA0..8'hA3), out_ready=1 → out_chan sequence 0,1,2,3,0 on consecutive cycles; out_valid stays high throughout.
- Round-robin backpressure: out_ready=0 for 3 cycles after the first capture → out_data held at the captured value, in_ready=0, pointer frozen; on release the next grant continues the rotation with no skip or repeat.
- Forced mode, sel=2, in_valid=4'b1111 → only channel 2 is granted each cycle; with sel=2 and in_valid[2]=0 → no grant and out_valid falls to 0 after the drain.
- Reset asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, pointer=0; the first round-robin grant after reset goes to channel 0.
- CHANNELS=3, round-robin, all channels valid → out_chan sequence 0,1,2,0; mode=11 behaves identically to fixed priority.
